// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter: core has fixed priority, loader is
// guaranteed a slot after MAX_HOLD consecutive core grants while it waits.
module dmem_arbiter #(
    parameter int MAX_HOLD = 4
) (
    input  logic        Clk,
    input  logic        Rst,

    input  logic        C_Req,
    input  logic        C_Wr,
    input  logic [31:0] C_Addr,
    input  logic [31:0] C_WrData,
    output logic        C_Gnt,
    output logic [31:0] C_RdData,
    output logic        C_RdValid,

    input  logic        L_Req,
    input  logic        L_Wr,
    input  logic [31:0] L_Addr,
    input  logic [31:0] L_WrData,
    output logic        L_Gnt,
    output logic [31:0] L_RdData,
    output logic        L_RdValid,

    output logic [31:0] M_Addr,
    output logic        M_Wr_en,
    output logic        M_Rd_en,
    output logic [31:0] M_Data_in,
    input  logic [31:0] M_Data_out
);

    localparam int HC_W = $clog2(MAX_HOLD + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CORE   = 2'd1,
        LOADER = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [HC_W-1:0] r_hc;
    logic            r_tag_valid;
    logic            w_c_gnt;
    logic            w_l_gnt;
    logic            w_hold_max;

    assign w_hold_max = (r_hc == HC_W'(MAX_HOLD));

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_c_gnt     = 1'b0;
        w_l_gnt     = 1'b0;
        w_state_nxt = IDLE;
        M_Addr      = 32'd0;
        M_Data_in   = 32'd0;
        M_Wr_en     = 1'b0;
        M_Rd_en     = 1'b0;

        if (!Rst) begin
            if (L_Req && w_hold_max) begin
                w_l_gnt = 1'b1;
            end else if (C_Req) begin
                w_c_gnt = 1'b1;
            end else if (L_Req) begin
                w_l_gnt = 1'b1;
            end
        end

        if (w_c_gnt) begin
            w_state_nxt = CORE;
            M_Addr      = C_Addr;
            M_Data_in   = C_WrData;
            M_Wr_en     = C_Wr;
            M_Rd_en     = !C_Wr;
        end else if (w_l_gnt) begin
            w_state_nxt = LOADER;
            M_Addr      = L_Addr;
            M_Data_in   = L_WrData;
            M_Wr_en     = L_Wr;
            M_Rd_en     = !L_Wr;
        end
    end

    assign C_Gnt = w_c_gnt;
    assign L_Gnt = w_l_gnt;

    // Saturates at MAX_HOLD; the forced loader grant then clears it.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_hc <= '0;
        end else if (!L_Req || w_l_gnt) begin
            r_hc <= '0;
        end else if (w_c_gnt && !w_hold_max) begin
            r_hc <= r_hc + 1'b1;
        end
    end

    // Read-tag owner is the previous cycle's grant owner, i.e. r_state.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_tag_valid <= 1'b0;
        end else begin
            r_tag_valid <= M_Rd_en;
        end
    end

    assign C_RdValid = !Rst && r_tag_valid && (r_state == CORE);
    assign L_RdValid = !Rst && r_tag_valid && (r_state == LOADER);
    assign C_RdData  = C_RdValid ? M_Data_out : 32'd0;
    assign L_RdData  = L_RdValid ? M_Data_out : 32'd0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a one-cycle-latency memory model.
module tb_dmem_arbiter;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        C_Req, C_Wr, L_Req, L_Wr;
    logic [31:0] C_Addr, C_WrData, L_Addr, L_WrData;
    logic        C_Gnt, C_RdValid, L_Gnt, L_RdValid;
    logic [31:0] C_RdData, L_RdData;
    logic [31:0] M_Addr, M_Data_in;
    logic        M_Wr_en, M_Rd_en;
    logic [31:0] M_Data_out;

    logic        preload;
    logic [31:0] mem [0:255];

    int n_tests = 0;
    int n_fail  = 0;

    dmem_arbiter #(.MAX_HOLD(4)) dut (
        .Clk(Clk), .Rst(Rst),
        .C_Req(C_Req), .C_Wr(C_Wr), .C_Addr(C_Addr), .C_WrData(C_WrData),
        .C_Gnt(C_Gnt), .C_RdData(C_RdData), .C_RdValid(C_RdValid),
        .L_Req(L_Req), .L_Wr(L_Wr), .L_Addr(L_Addr), .L_WrData(L_WrData),
        .L_Gnt(L_Gnt), .L_RdData(L_RdData), .L_RdValid(L_RdValid),
        .M_Addr(M_Addr), .M_Wr_en(M_Wr_en), .M_Rd_en(M_Rd_en),
        .M_Data_in(M_Data_in), .M_Data_out(M_Data_out)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        if (preload) begin
            mem[4] <= 32'hDEADBEEF;
            mem[8] <= 32'd0;
        end
        if (M_Wr_en) mem[M_Addr[9:2]] <= M_Data_in;
        if (M_Rd_en) M_Data_out <= mem[M_Addr[9:2]];
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge Clk);
        @(negedge Clk);
    endtask

    initial begin
        string   seq;
        int      hc_exp [10];
        hc_exp = '{1, 2, 3, 4, 0, 1, 2, 3, 4, 0};
        seq    = "CCCCLCCCCL";

        Rst = 1'b1; preload = 1'b1;
        C_Req = 0; C_Wr = 0; C_Addr = 0; C_WrData = 0;
        L_Req = 0; L_Wr = 0; L_Addr = 0; L_WrData = 0;

        // Reset: requests are ignored and every output is quiet.
        @(negedge Clk);
        C_Req = 1; C_Addr = 32'h10; L_Req = 1; L_Addr = 32'h20;
        #2;
        check("rst_c_gnt",  32'(C_Gnt), 0);
        check("rst_l_gnt",  32'(L_Gnt), 0);
        check("rst_rd_en",  32'(M_Rd_en), 0);
        check("rst_m_addr", M_Addr, 0);
        check("rst_c_rdv",  32'(C_RdValid), 0);
        tick;
        check("rst_state",  32'(dut.r_state), 0);
        check("rst_hc",     32'(dut.r_hc), 0);

        // First cycle after reset: core-only read of 0x10.
        preload = 0; Rst = 0; L_Req = 0;
        #2;
        check("rd_c_gnt",  32'(C_Gnt), 1);
        check("rd_rd_en",  32'(M_Rd_en), 1);
        check("rd_wr_en",  32'(M_Wr_en), 0);
        check("rd_m_addr", M_Addr, 32'h10);
        tick;
        C_Req = 0;
        #2;
        check("rd_c_rdv",  32'(C_RdValid), 1);
        check("rd_c_data", C_RdData, 32'hDEADBEEF);
        check("rd_l_rdv",  32'(L_RdValid), 0);
        check("rd_l_data", L_RdData, 0);
        tick;

        // Loader writes 0x55 to 0x20, core reads it back next cycle.
        L_Req = 1; L_Wr = 1; L_Addr = 32'h20; L_WrData = 32'h55;
        #2;
        check("wr_l_gnt",   32'(L_Gnt), 1);
        check("wr_wr_en",   32'(M_Wr_en), 1);
        check("wr_rd_en",   32'(M_Rd_en), 0);
        check("wr_m_addr",  M_Addr, 32'h20);
        check("wr_m_din",   M_Data_in, 32'h55);
        tick;
        L_Req = 0; L_Wr = 0; C_Req = 1; C_Wr = 0; C_Addr = 32'h20;
        #2;
        check("il_c_gnt",   32'(C_Gnt), 1);
        check("il_l_rdv",   32'(L_RdValid), 0);
        tick;
        C_Req = 0;
        #2;
        check("il_c_rdv",   32'(C_RdValid), 1);
        check("il_c_data",  C_RdData, 32'h55);
        check("il_l_rdv2",  32'(L_RdValid), 0);
        tick;

        // Back-to-back reads by different owners.
        C_Req = 1; C_Addr = 32'h10;
        tick;
        C_Req = 0; L_Req = 1; L_Wr = 0; L_Addr = 32'h20;
        #2;
        check("bb_l_gnt",   32'(L_Gnt), 1);
        check("bb_c_rdv",   32'(C_RdValid), 1);
        check("bb_c_data",  C_RdData, 32'hDEADBEEF);
        check("bb_l_data0", L_RdData, 0);
        tick;
        L_Req = 0;
        #2;
        check("bb_l_rdv",   32'(L_RdValid), 1);
        check("bb_l_data",  L_RdData, 32'h55);
        check("bb_c_rdv2",  32'(C_RdValid), 0);
        check("bb_c_data0", C_RdData, 0);
        tick;

        // Contention with MAX_HOLD=4.
        C_Req = 1; C_Wr = 0; C_Addr = 32'h10;
        L_Req = 1; L_Wr = 0; L_Addr = 32'h20;
        for (int i = 0; i < 10; i++) begin
            #2;
            check($sformatf("ct_c_gnt%0d", i), 32'(C_Gnt), (seq[i] == "C") ? 1 : 0);
            check($sformatf("ct_l_gnt%0d", i), 32'(L_Gnt), (seq[i] == "L") ? 1 : 0);
            check($sformatf("ct_addr%0d", i), M_Addr, (seq[i] == "C") ? 32'h10 : 32'h20);
            tick;
            check($sformatf("ct_hc%0d", i), 32'(dut.r_hc), 32'(hc_exp[i]));
        end
        L_Req = 0;
        tick;
        C_Req = 0;
        tick;

        // Reset asserted while a read is outstanding and another is requested.
        C_Req = 1; C_Addr = 32'h10;
        tick;
        Rst = 1;
        #2;
        check("mr_c_gnt",   32'(C_Gnt), 0);
        check("mr_rd_en",   32'(M_Rd_en), 0);
        check("mr_c_rdv",   32'(C_RdValid), 0);
        check("mr_c_data",  C_RdData, 0);
        check("mr_m_addr",  M_Addr, 0);
        tick;
        #2;
        check("mr_c_rdv2",  32'(C_RdValid), 0);
        check("mr_state",   32'(dut.r_state), 0);
        tick;
        Rst = 0;
        #2;
        check("mr_regnt",   32'(C_Gnt), 1);
        tick;
        C_Req = 0;
        #2;
        check("mr_c_rdv3",  32'(C_RdValid), 1);
        check("mr_c_data3", C_RdData, 32'hDEADBEEF);
        tick;

        // Idle for ten cycles.
        for (int i = 0; i < 10; i++) begin
            #2;
            check($sformatf("id_gnt%0d", i),   32'({C_Gnt, L_Gnt}), 0);
            check($sformatf("id_en%0d", i),    32'({M_Rd_en, M_Wr_en}), 0);
            check($sformatf("id_addr%0d", i),  M_Addr, 0);
            tick;
            check($sformatf("id_state%0d", i), 32'(dut.r_state), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 4; it is the maximum number of consecutive core grants while the loader is requesting.
REQ-002 SHALL have port Clk  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port Rst  in  1  reset; one clock, reset is synchronous and active-high.
REQ-004 SHALL have ports C_Req in 1, C_Wr in 1, C_Addr in 32, C_WrData in 32: core load/store request, write flag, byte address, write data.
REQ-005 SHALL have ports C_Gnt out 1, C_RdData out 32, C_RdValid out 1: core grant, read data, read-data-valid.
REQ-006 SHALL have ports L_Req, L_Wr, L_Addr, L_WrData, L_Gnt, L_RdData, L_RdValid, identical in widths and meaning to the C_* ports, for the program-loader/debug requester.
REQ-007 SHALL have ports M_Addr out 32, M_Wr_en out 1, M_Rd_en out 1, M_Data_in out 32 (towards data memory), and M_Data_out in 32 (memory read data, valid one cycle after M_Rd_en).

Function
REQ-008 SHALL implement FSM {IDLE, CORE, LOADER}; state = owner of the previous cycle's grant, IDLE if no grant.
REQ-009 SHALL grant at most one requester per cycle; Gnt is combinational in the cycle the access is issued.
REQ-010 SHALL give the core fixed priority when both request, except as required by REQ-011.
REQ-011 SHALL keep hold counter HC (0..MAX_HOLD): HC increments on each core grant while L_Req=1, clears on any loader grant or when L_Req=0; when HC==MAX_HOLD and L_Req=1, the loader wins regardless of C_Req.
REQ-012 SHALL drive M_Addr/M_Data_in from the winner; M_Wr_en = winner Wr; M_Rd_en = winner !Wr.
REQ-013 SHALL drive M_Addr=0, M_Data_in=0, M_Wr_en=0, M_Rd_en=0 in any cycle with no grant.
REQ-014 SHALL register a 2-bit read tag {valid, owner} at each granted read, and assert exactly that owner's RdValid for one cycle on the next cycle.
REQ-015 SHALL route M_Data_out to the tagged owner's RdData; the non-tagged port's RdData SHALL hold 0.
REQ-016 SHALL support back-to-back grants every cycle, including a read by one port followed next cycle by a read or write by the other, with no lost or misrouted data.
REQ-017 SHALL treat a requester as waiting until Gnt; a requester dropping Req before Gnt receives nothing.
REQ-018 SHALL produce no RdValid for writes.

Reset
REQ-019 SHALL, while Rst=1, force state=IDLE, HC=0, read tag invalid, both Gnt=0, both RdValid=0, both RdData=0, and all M_* outputs=0.
REQ-020 SHALL discard a read issued in the cycle Rst rises, so that no RdValid follows it.
REQ-021 SHALL accept requests in the first cycle after Rst falls.

Verification
REQ-022 Core-only read: C_Req=1, C_Wr=0, C_Addr=0x10, memory holds 0xDEADBEEF at 0x10 -> C_Gnt=1, M_Rd_en=1, M_Addr=0x10 in cycle t; C_RdValid=1, C_RdData=0xDEADBEEF in t+1; L_RdValid=0 throughout.
REQ-023 Contention fairness: C_Req=L_Req=1 held continuously with MAX_HOLD=4 -> grant sequence C,C,C,C,L,C,C,C,C,L; HC returns to 0 after each L grant.
REQ-024 Interleaved: loader writes 0x55 to 0x20 in cycle t, core reads 0x20 in t+1 -> M_Wr_en=1 in t; C_RdData=0x55 with C_RdValid=1 in t+2; no L_RdValid.
REQ-025 Reset mid-read: core read granted in cycle t with Rst=1 in t -> C_RdValid=0 in t+1; all outputs 0 while Rst=1; a grant is issued in the first cycle after Rst=0.
REQ-026 Idle: C_Req=L_Req=0 for 10 cycles -> Gnt=0, M_Rd_en=M_Wr_en=0, M_Addr=0, and state=IDLE each cycle.
